// File: rtl/booth_mult_seq_pkg.sv
// Shared encodings for the sequential radix-2 Booth multiplier:
// FSM state codes, Booth operation codes and the counter-width helper.
package booth_mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10
  } booth_op_e;

  // Booth recoding of the current multiplier bit pair {Q[0], q_1}
  function automatic booth_op_e booth_decode(input logic q0, input logic q_1);
    booth_op_e op;
    case ({q0, q_1})
      2'b01:   op = OP_ADD;
      2'b10:   op = OP_SUB;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

  // Step counter width; never below one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/booth_mult_seq_step.sv
// One combinational radix-2 Booth step: conditional add of M or -M into the
// accumulator, then an arithmetic right shift of {acc, Q, q_1}.
module booth_step
  import booth_mult_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N:0]   acc,
  input  logic [N-1:0] q,
  input  logic         q_1,
  input  logic [N:0]   m,
  input  logic [N:0]   neg_m,
  output logic [N:0]   acc_nxt,
  output logic [N-1:0] q_nxt,
  output logic         q_1_nxt
);

  booth_op_e  op_s;
  logic [N:0] sum_s;

  assign op_s = booth_decode(q[0], q_1);

  // Add/subtract selected by the recoded bit pair
  always_comb begin
    sum_s = acc;
    case (op_s)
      OP_ADD:  sum_s = acc + m;
      OP_SUB:  sum_s = acc + neg_m;
      default: sum_s = acc;
    endcase
  end

  // Arithmetic shift right, replicating the accumulator sign bit
  always_comb begin
    acc_nxt = {sum_s[N], sum_s[N:1]};
    q_nxt   = {sum_s[0], q[N-1:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier: one multiplier bit per clock,
// full 2N-bit product returned through a start/busy/done handshake.
module booth_mult_seq
  import booth_mult_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  localparam int               CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [N:0]       NEG_INC  = {{N{1'b0}}, 1'b1};

  state_e           state_r, next_state_s;
  logic [N:0]       acc_r, m_r, neg_m_r, acc_nxt_s, m_load_s;
  logic [N-1:0]     q_r, q_nxt_s;
  logic             q_1_r, q_1_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic [2*N-1:0]   p_r;
  logic             busy_r, done_r, busy_nxt_s, done_nxt_s;
  logic             last_step_s;

  // The extra sign bit keeps -M exact when A is the most negative value
  assign m_load_s    = {A[N-1], A};
  assign last_step_s = (count_r == LAST_CNT);

  booth_step #(.N(N)) u_step (
    .acc     (acc_r),
    .q       (q_r),
    .q_1     (q_1_r),
    .m       (m_r),
    .neg_m   (neg_m_r),
    .acc_nxt (acc_nxt_s),
    .q_nxt   (q_nxt_s),
    .q_1_nxt (q_1_nxt_s)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; start during RUN is deliberately ignored
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = IDLE;
      end
      RUN: begin
        if (last_step_s) next_state_s = DONE;
        else             next_state_s = RUN;
      end
      DONE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // FSM output decode, computed one cycle ahead so busy/done come from flops
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (next_state_s)
      RUN:     busy_nxt_s = 1'b1;
      DONE:    done_nxt_s = 1'b1;
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Operand load, Booth iteration, product capture and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_r   <= '0;
      m_r     <= '0;
      neg_m_r <= '0;
      q_r     <= '0;
      q_1_r   <= 1'b0;
      count_r <= '0;
      p_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            acc_r   <= '0;
            q_r     <= B;
            q_1_r   <= 1'b0;
            m_r     <= m_load_s;
            neg_m_r <= (~m_load_s) + NEG_INC;
            count_r <= '0;
          end
        end
        RUN: begin
          acc_r   <= acc_nxt_s;
          q_r     <= q_nxt_s;
          q_1_r   <= q_1_nxt_s;
          count_r <= count_r + CNT_ONE;
          if (last_step_s) p_r <= {acc_nxt_s[N-1:0], q_nxt_s};
        end
        default: ;
      endcase
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign P    = p_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks of booth_mult_seq at N=8 and N=32.
module tb_booth_mult_seq;

  logic        clk, rst;
  logic        start8, start32;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        busy8, done8, busy32, done32;
  logic [15:0] p8;
  logic [63:0] p32;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult_seq #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8)
  );

  booth_mult_seq #(.N(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .P(p32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cur_done(input int w);
    return (w == 8) ? done8 : done32;
  endfunction

  function automatic logic cur_busy(input int w);
    return (w == 8) ? busy8 : busy32;
  endfunction

  // Issue one operation, count cycles after the start edge until done is seen
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] p, output int lat, output int busy_cnt,
                        output int overlap, output int pulse_bad);
    @(negedge clk);
    if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
    else begin a32 = a; b32 = b; start32 = 1'b1; end
    @(posedge clk); #1;
    start8 = 1'b0; start32 = 1'b0;
    lat = 0; busy_cnt = 0; overlap = 0;
    while (!cur_done(w) && lat < 64) begin
      @(negedge clk);
      lat++;
      if (cur_busy(w)) busy_cnt++;
      if (cur_busy(w) && cur_done(w)) overlap++;
    end
    p = (w == 8) ? {48'h0, p8} : p32;
    @(negedge clk);
    pulse_bad = cur_done(w) ? 1 : 0;
  endtask

  task automatic op_check(input string tag, input int w, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
    logic [63:0] p;
    int lat, bc, ov, pb;
    run_op(w, a, b, p, lat, bc, ov, pb);
    chk({tag, "_p"}, p, exp);
    chk({tag, "_lat"}, 64'(lat), 64'(w + 1));
    chk({tag, "_busy"}, 64'(bc), 64'(w));
    chk({tag, "_excl"}, 64'(ov + pb), 64'(0));
  endtask

  initial begin
    int c, dcnt;
    longint pr;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    rst = 1'b0; start8 = 1'b0; start32 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a32 = 32'h0; b32 = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy8", 64'(busy8), 64'(0));
    chk("rst_done8", 64'(done8), 64'(0));
    chk("rst_p8", 64'(p8), 64'(0));
    chk("rst_busy32", 64'(busy32), 64'(0));
    chk("rst_done32", 64'(done32), 64'(0));
    chk("rst_p32", p32, 64'h0);
    rst = 1'b1;

    op_check("m3x5", 8, 32'd3, 32'd5, 64'h000F);
    op_check("mn7x6", 8, 32'hF9, 32'd6, 64'hFFD6);
    op_check("m6xn7", 8, 32'd6, 32'hF9, 64'hFFD6);
    op_check("mmin_sq", 8, 32'h80, 32'h80, 64'h4000);
    op_check("m0xn1", 8, 32'h00, 32'hFF, 64'h0000);
    op_check("mminxmax", 8, 32'h80, 32'h7F, 64'hC080);
    op_check("w_min_sq", 32, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    op_check("w_n1xmax", 32, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001);

    // start during RUN is ignored; a start in the DONE cycle chains with no gap
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd5; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    c = 0;
    while (!done8 && c < 64) begin
      @(negedge clk);
      c++;
      if (c == 3) begin a8 = 8'd100; b8 = 8'd100; start8 = 1'b1; end
      if (c == 4) start8 = 1'b0;
      if (c == 5) chk("ign_p_hold", 64'(p8), 64'hC080);
    end
    chk("ign_lat", 64'(c), 64'(9));
    chk("ign_p", 64'(p8), 64'h000F);
    a8 = 8'hFE; b8 = 8'hFD; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 64'(busy8), 64'(1));
    c = 1;
    while (!done8 && c < 64) begin
      @(negedge clk);
      c++;
    end
    chk("b2b_lat", 64'(c), 64'(9));
    chk("b2b_p", 64'(p8), 64'h0006);

    // reset in the middle of an operation aborts it silently
    @(negedge clk);
    a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy8), 64'(0));
    chk("abort_done", 64'(done8), 64'(0));
    chk("abort_p", 64'(p8), 64'h0);
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    chk("abort_nodone", 64'(dcnt), 64'(0));
    op_check("m9x9", 8, 32'd9, 32'd9, 64'h0051);

    for (int i = 0; i < 800; i++) begin
      ra = $urandom; rb = $urandom;
      pr = longint'($signed(ra[7:0])) * longint'($signed(rb[7:0]));
      exp = {48'h0, pr[15:0]};
      op_check("rnd8", 8, ra, rb, exp);
    end
    for (int i = 0; i < 800; i++) begin
      ra = $urandom; rb = $urandom;
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'h8000_0000;
      pr = longint'($signed(ra)) * longint'($signed(rb));
      op_check("rnd32", 32, ra, rb, pr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
